blosum_compare: RTL and testbench
=================================

BLOSUM_COMPARE -- requirements
Module: blosum_compare

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list, in this order:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- seq1  input  protein_base (5 bits)  first residue code
- seq2  input  protein_base (5 bits)  second residue code
- score  output  16  signed two's-complement substitution score
REQ-003 SHALL use protein_base from datatypesPkg, encoded alphabetically: A=0, B=1, … Z=25; codes 26-31 are illegal.

Function
REQ-004 SHALL output the BLOSUM62 substitution score (NCBI standard, half-bit units) for the pair (seq1, seq2).
REQ-005 SHALL produce a symmetric result: score(a,b) = score(b,a) for all codes.
REQ-006 Matrix alphabet SHALL be A R N D C Q E G H I L K M F P S T W Y V B Z X.
REQ-007 SHALL treat J, O, U and illegal codes 26-31 as X before lookup.
REQ-008 X-vs-any score SHALL follow NCBI BLOSUM62: X/X = -1, A/X = 0, C/X = -2, W/X = -2.
REQ-009 The 8-bit table value SHALL be sign-extended to 16 bits; the range is -4..+11.
REQ-010 score SHALL be registered with a latency of 1 cycle: the value at rising edge N reflects the seq1/seq2 values sampled at edge N.
REQ-011 SHALL register score every cycle while reset is low; it has no enable and no stall.
REQ-012 Inputs SHALL be sampled only at rising edges; combinational glitches on seq1/seq2 between edges SHALL NOT affect score.
REQ-013 Implementation SHALL be a case/ROM lookup with no arithmetic, and SHALL be synthesizable with no latches.
REQ-014 Required spot values:
- Row A against A..Z: 4,-2,0,-2,-1,-2,0,-2,-1,(J→X)0,-1,-1,-1,-2,(O)0,-1,-1,-1,1,0,(U)0,0,-3,0,-2,-1
- Diagonal: C/C=9, W/W=11, H/H=8, P/P=7, Y/Y=7, F/F=6, L/L=4
- Others: B/D=4, Z/E=4, W/C=-2, I/V=3, K/R=2

Reset
REQ-015 While reset is high at a rising edge, score SHALL become 16'h0000 at that edge, regardless of the inputs.
REQ-016 On the first rising edge with reset low, score SHALL take the lookup of the inputs sampled at that edge.
REQ-017 Reset asserted in the middle of a stream SHALL override that cycle's lookup; there SHALL be no other internal state.

Verification
REQ-018 Hold reset high for 2 cycles with seq1=A, seq2=W -> score = 0; release reset -> next edge score = 16'hFFFD (-3).
REQ-019 seq1=A; seq2 stepped A..Z, one per cycle (period 10) -> score sequence equals the REQ-014 row A, each delayed one cycle.
REQ-020 Swapped pairs (W,C)/(C,W) and (I,V)/(V,I) -> score equals -2 and 3 respectively in both orders.
REQ-021 Diagonal C/C and W/W -> 9 and 11; J/J, O/U and code 31 vs A -> -1, -1 and 0 (treated as X).
REQ-022 Random pairs for 1000 cycles versus a golden BLOSUM62 model, with reset pulsed randomly -> every cycle matches the model delayed one cycle, and score = 0 after each reset edge.

Source files
------------

// File: rtl/blosum_compare.sv
// BLOSUM62 substitution score for a pair of residue codes, registered with one cycle of latency.
// Residue codes are alphabetical (A=0 .. Z=25); J, O, U and codes 26-31 are looked up as X.
package datatypesPkg;
    typedef logic [4:0] protein_base;
endpackage

module blosum_compare
    import datatypesPkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  protein_base seq1,
    input  protein_base seq2,
    output logic [15:0] score
);

    localparam int unsigned NumSym = 23;

    // Rows and columns in NCBI order: A R N D C Q E G H I L K M F P S T W Y V B Z X.
    localparam logic [0:NumSym-1][0:NumSym-1][7:0] Blosum62 = {
        184'h04_ff_fe_fe_00_ff_ff_00_fe_ff_ff_ff_ff_fe_ff_01_00_fd_fe_00_fe_ff_00, // A
        184'hff_05_00_fe_fd_01_00_fe_00_fd_fe_02_ff_fd_fe_ff_ff_fd_fe_fd_ff_00_ff, // R
        184'hfe_00_06_01_fd_00_00_00_01_fd_fd_00_fe_fd_fe_01_00_fc_fe_fd_03_00_ff, // N
        184'hfe_fe_01_06_fd_00_02_ff_ff_fd_fc_ff_fd_fd_ff_00_ff_fc_fd_fd_04_01_ff, // D
        184'h00_fd_fd_fd_09_fd_fc_fd_fd_ff_ff_fd_ff_fe_fd_ff_ff_fe_fe_ff_fd_fd_fe, // C
        184'hff_01_00_00_fd_05_02_fe_00_fd_fe_01_00_fd_ff_00_ff_fe_ff_fe_00_03_ff, // Q
        184'hff_00_00_02_fc_02_05_fe_00_fd_fd_01_fe_fd_ff_00_ff_fd_fe_fe_01_04_ff, // E
        184'h00_fe_00_ff_fd_fe_fe_06_fe_fc_fc_fe_fd_fd_fe_00_fe_fe_fd_fd_ff_fe_ff, // G
        184'hfe_00_01_ff_fd_00_00_fe_08_fd_fd_ff_fe_ff_fe_ff_fe_fe_02_fd_00_00_ff, // H
        184'hff_fd_fd_fd_ff_fd_fd_fc_fd_04_02_fd_01_00_fd_fe_ff_fd_ff_03_fd_fd_ff, // I
        184'hff_fe_fd_fc_ff_fe_fd_fc_fd_02_04_fe_02_00_fd_fe_ff_fe_ff_01_fc_fd_ff, // L
        184'hff_02_00_ff_fd_01_01_fe_ff_fd_fe_05_ff_fd_ff_00_ff_fd_fe_fe_00_01_ff, // K
        184'hff_ff_fe_fd_ff_00_fe_fd_fe_01_02_ff_05_00_fe_ff_ff_ff_ff_01_fd_ff_ff, // M
        184'hfe_fd_fd_fd_fe_fd_fd_fd_ff_00_00_fd_00_06_fc_fe_fe_01_03_ff_fd_fd_ff, // F
        184'hff_fe_fe_ff_fd_ff_ff_fe_fe_fd_fd_ff_fe_fc_07_ff_ff_fc_fd_fe_fe_ff_fe, // P
        184'h01_ff_01_00_ff_00_00_00_ff_fe_fe_00_ff_fe_ff_04_01_fd_fe_fe_00_00_00, // S
        184'h00_ff_00_ff_ff_ff_ff_fe_fe_ff_ff_ff_ff_fe_ff_01_05_fe_fe_00_ff_ff_00, // T
        184'hfd_fd_fc_fc_fe_fe_fd_fe_fe_fd_fe_fd_ff_01_fc_fd_fe_0b_02_fd_fc_fd_fe, // W
        184'hfe_fe_fe_fd_fe_ff_fe_fd_02_ff_ff_fe_ff_03_fd_fe_fe_02_07_ff_fd_fe_ff, // Y
        184'h00_fd_fd_fd_ff_fe_fe_fd_fd_03_01_fe_01_ff_fe_fe_00_fd_ff_04_fd_fe_ff, // V
        184'hfe_ff_03_04_fd_00_01_ff_00_fd_fc_00_fd_fd_fe_00_ff_fc_fd_fd_04_01_ff, // B
        184'hff_00_00_01_fd_03_04_fe_00_fd_fd_01_ff_fd_ff_00_ff_fd_fe_fe_01_04_ff, // Z
        184'h00_ff_ff_ff_fe_ff_ff_ff_ff_ff_ff_ff_ff_ff_fe_00_00_fe_ff_ff_ff_ff_ff  // X
    };

    function automatic logic [4:0] matrix_index(input protein_base code);
        logic [4:0] idx;
        case (code)
            5'd0:    idx = 5'd0;   // A
            5'd1:    idx = 5'd20;  // B
            5'd2:    idx = 5'd4;   // C
            5'd3:    idx = 5'd3;   // D
            5'd4:    idx = 5'd6;   // E
            5'd5:    idx = 5'd13;  // F
            5'd6:    idx = 5'd7;   // G
            5'd7:    idx = 5'd8;   // H
            5'd8:    idx = 5'd9;   // I
            5'd10:   idx = 5'd11;  // K
            5'd11:   idx = 5'd10;  // L
            5'd12:   idx = 5'd12;  // M
            5'd13:   idx = 5'd2;   // N
            5'd15:   idx = 5'd14;  // P
            5'd16:   idx = 5'd5;   // Q
            5'd17:   idx = 5'd1;   // R
            5'd18:   idx = 5'd15;  // S
            5'd19:   idx = 5'd16;  // T
            5'd21:   idx = 5'd19;  // V
            5'd22:   idx = 5'd17;  // W
            5'd24:   idx = 5'd18;  // Y
            5'd25:   idx = 5'd21;  // Z
            default: idx = 5'd22;  // X, J, O, U and illegal codes
        endcase
        return idx;
    endfunction

    logic [4:0]  idx1;
    logic [4:0]  idx2;
    logic [7:0]  entry;
    logic [15:0] score_d;
    logic [15:0] score_q;

    always_comb begin
        idx1    = matrix_index(seq1);
        idx2    = matrix_index(seq2);
        entry   = Blosum62[idx1][idx2];
        score_d = {{8{entry[7]}}, entry};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: tb/tb_blosum_compare.sv
// Directed and randomized checks of blosum_compare against hand values and a BLOSUM62 model.
module tb_blosum_compare;
    import datatypesPkg::*;

    logic        clk = 1'b0;
    logic        reset;
    protein_base seq1;
    protein_base seq2;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blosum_compare dut (
        .clk   (clk),
        .reset (reset),
        .seq1  (seq1),
        .seq2  (seq2),
        .score (score)
    );

    // Independent golden table, NCBI order A R N D C Q E G H I L K M F P S T W Y V B Z X.
    int blosum [23][23] = '{
        '{ 4,-1,-2,-2, 0,-1,-1, 0,-2,-1,-1,-1,-1,-2,-1, 1, 0,-3,-2, 0,-2,-1, 0},
        '{-1, 5, 0,-2,-3, 1, 0,-2, 0,-3,-2, 2,-1,-3,-2,-1,-1,-3,-2,-3,-1, 0,-1},
        '{-2, 0, 6, 1,-3, 0, 0, 0, 1,-3,-3, 0,-2,-3,-2, 1, 0,-4,-2,-3, 3, 0,-1},
        '{-2,-2, 1, 6,-3, 0, 2,-1,-1,-3,-4,-1,-3,-3,-1, 0,-1,-4,-3,-3, 4, 1,-1},
        '{ 0,-3,-3,-3, 9,-3,-4,-3,-3,-1,-1,-3,-1,-2,-3,-1,-1,-2,-2,-1,-3,-3,-2},
        '{-1, 1, 0, 0,-3, 5, 2,-2, 0,-3,-2, 1, 0,-3,-1, 0,-1,-2,-1,-2, 0, 3,-1},
        '{-1, 0, 0, 2,-4, 2, 5,-2, 0,-3,-3, 1,-2,-3,-1, 0,-1,-3,-2,-2, 1, 4,-1},
        '{ 0,-2, 0,-1,-3,-2,-2, 6,-2,-4,-4,-2,-3,-3,-2, 0,-2,-2,-3,-3,-1,-2,-1},
        '{-2, 0, 1,-1,-3, 0, 0,-2, 8,-3,-3,-1,-2,-1,-2,-1,-2,-2, 2,-3, 0, 0,-1},
        '{-1,-3,-3,-3,-1,-3,-3,-4,-3, 4, 2,-3, 1, 0,-3,-2,-1,-3,-1, 3,-3,-3,-1},
        '{-1,-2,-3,-4,-1,-2,-3,-4,-3, 2, 4,-2, 2, 0,-3,-2,-1,-2,-1, 1,-4,-3,-1},
        '{-1, 2, 0,-1,-3, 1, 1,-2,-1,-3,-2, 5,-1,-3,-1, 0,-1,-3,-2,-2, 0, 1,-1},
        '{-1,-1,-2,-3,-1, 0,-2,-3,-2, 1, 2,-1, 5, 0,-2,-1,-1,-1,-1, 1,-3,-1,-1},
        '{-2,-3,-3,-3,-2,-3,-3,-3,-1, 0, 0,-3, 0, 6,-4,-2,-2, 1, 3,-1,-3,-3,-1},
        '{-1,-2,-2,-1,-3,-1,-1,-2,-2,-3,-3,-1,-2,-4, 7,-1,-1,-4,-3,-2,-2,-1,-2},
        '{ 1,-1, 1, 0,-1, 0, 0, 0,-1,-2,-2, 0,-1,-2,-1, 4, 1,-3,-2,-2, 0, 0, 0},
        '{ 0,-1, 0,-1,-1,-1,-1,-2,-2,-1,-1,-1,-1,-2,-1, 1, 5,-2,-2, 0,-1,-1, 0},
        '{-3,-3,-4,-4,-2,-2,-3,-2,-2,-3,-2,-3,-1, 1,-4,-3,-2,11, 2,-3,-4,-3,-2},
        '{-2,-2,-2,-3,-2,-1,-2,-3, 2,-1,-1,-2,-1, 3,-3,-2,-2, 2, 7,-1,-3,-2,-1},
        '{ 0,-3,-3,-3,-1,-2,-2,-3,-3, 3, 1,-2, 1,-1,-2,-2, 0,-3,-1, 4,-3,-2,-1},
        '{-2,-1, 3, 4,-3, 0, 1,-1, 0,-3,-4, 0,-3,-3,-2, 0,-1,-4,-3,-3, 4, 1,-1},
        '{-1, 0, 0, 1,-3, 3, 4,-2, 0,-3,-3, 1,-1,-3,-1, 0,-1,-3,-2,-2, 1, 4,-1},
        '{ 0,-1,-1,-1,-2,-1,-1,-1,-1,-1,-1,-1,-1,-1,-2, 0, 0,-2,-1,-1,-1,-1,-1}
    };

    function automatic int bidx(input int code);
        string alpha = "ARNDCQEGHILKMFPSTWYVBZX";
        int    ch    = 65 + code;
        int    r     = 22;
        for (int i = 0; i < 23; i++) begin
            if (int'(alpha[i]) == ch) r = i;
        end
        return r;
    endfunction

    function automatic logic [15:0] golden(input int a, input int b);
        return 16'(blosum[bidx(a)][bidx(b)]);
    endfunction

    // Apply one input pair and return #1 after the capturing edge.
    task automatic drive(input int a, input int b, input logic r);
        seq1  = protein_base'(a);
        seq2  = protein_base'(b);
        reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(0, 22, 1'b1);
            checks++;
            if (score !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 0000", c, score);
            end
        end
        drive(0, 22, 1'b0);
        checks++;
        if (score !== 16'hFFFD) begin
            errors++;
            $display("FAIL reset_release: got %h expected fffd", score);
        end
    endtask

    task automatic test_row_a();
        int row_a [26] = '{4,-2,0,-2,-1,-2,0,-2,-1,0,-1,-1,-1,-2,0,-1,-1,-1,1,0,0,0,-3,0,-2,-1};
        logic [15:0] exp;
        for (int k = 0; k < 26; k++) begin
            drive(0, k, 1'b0);
            exp = 16'(row_a[k]);
            checks++;
            if (score !== exp) begin
                errors++;
                $display("FAIL row_a[%0d]: got %h expected %h", k, score, exp);
            end
        end
    endtask

    task automatic test_swapped();
        int a_tab [4] = '{22, 2, 8, 21};
        int b_tab [4] = '{2, 22, 21, 8};
        int e_tab [4] = '{-2, -2, 3, 3};
        logic [15:0] exp;
        for (int k = 0; k < 4; k++) begin
            drive(a_tab[k], b_tab[k], 1'b0);
            exp = 16'(e_tab[k]);
            checks++;
            if (score !== exp) begin
                errors++;
                $display("FAIL swapped[%0d]: got %h expected %h", k, score, exp);
            end
            // Input activity between edges must not reach the output.
            seq1 = 5'd22;
            seq2 = 5'd22;
            #2;
            checks++;
            if (score !== exp) begin
                errors++;
                $display("FAIL glitch[%0d]: got %h expected %h", k, score, exp);
            end
        end
    endtask

    task automatic test_diagonal_x();
        // C/C W/W J/J O/U 31/A H/H P/P Y/Y F/F L/L B/D Z/E K/R
        int a_tab [13] = '{2, 22, 9, 14, 31, 7, 15, 24, 5, 11, 1, 25, 10};
        int b_tab [13] = '{2, 22, 9, 20, 0, 7, 15, 24, 5, 11, 3, 4, 17};
        int e_tab [13] = '{9, 11, -1, -1, 0, 8, 7, 7, 6, 4, 4, 4, 2};
        logic [15:0] exp;
        for (int k = 0; k < 13; k++) begin
            drive(a_tab[k], b_tab[k], 1'b0);
            exp = 16'(e_tab[k]);
            checks++;
            if (score !== exp) begin
                errors++;
                $display("FAIL diag_x[%0d]: got %h expected %h", k, score, exp);
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(22, 22, 1'b1);
        checks++;
        if (score !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0000", score);
        end
        drive(2, 2, 1'b0);
        checks++;
        if (score !== 16'h0009) begin
            errors++;
            $display("FAIL mid_reset_release: got %h expected 0009", score);
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        logic r;
        logic [15:0] exp;
        for (int k = 0; k < 1000; k++) begin
            a = int'($urandom_range(0, 31));
            b = int'($urandom_range(0, 31));
            r = ($urandom_range(0, 19) == 0);
            drive(a, b, r);
            exp = r ? 16'h0000 : golden(a, b);
            checks++;
            if (score !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%0d b=%0d rst=%0b: got %h expected %h",
                         k, a, b, r, score, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        seq1  = '0;
        seq2  = '0;
        test_reset();
        test_row_a();
        test_swapped();
        test_diagonal_x();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
